fifo_rr_arbiter: RTL
====================

FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 Parameter: DATA_W, default 6, width of each source word and of the output word.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset_L  input  1  asynchronous, active-low reset.
REQ-004 Port: fifo_empty  input  4  bit i is the empty flag of source FIFO i.
REQ-005 Port: fifo_data  input  4*DATA_W  word i is source FIFO i data output, in bits [i*DATA_W +: DATA_W].
REQ-006 Port: fifo_valid  input  4  bit i is the valid_out of source FIFO i; high the cycle after a pop.
REQ-007 Port: dest_pause  input  1  destination FIFO almost-full (PAUSE).
REQ-008 Port: dest_continue  input  1  destination FIFO almost-empty (CONTINUE).
REQ-009 Port: pop  output  4  one-hot-or-zero pop to the source FIFOs.
REQ-010 Port: push_out  output  1  push to the destination FIFO.
REQ-011 Port: data_out  output  DATA_W  word pushed to the destination.
REQ-012 Port: src_out  output  2  index of the source that supplied data_out.
REQ-013 Port: err  output  1  sticky protocol-error flag.

Function
REQ-014 FSM states: IDLE, ACTIVE, PAUSED; the reset state is IDLE.
REQ-015 IDLE->ACTIVE when any fifo_empty bit is 0 and dest_pause=0; ACTIVE->IDLE when all fifo_empty bits are 1.
REQ-016 ACTIVE or IDLE->PAUSED when dest_pause=1; PAUSED->ACTIVE when dest_continue=1 and dest_pause=0; dest_pause wins if both are high.
REQ-017 pop is asserted combinationally in ACTIVE only, at most one bit per cycle, and never for a source whose fifo_empty is 1 in that cycle.
REQ-018 The grant search starts at (last_grant+1) mod 4; last_grant updates on every cycle with a pop.
REQ-019 Back-to-back pops are allowed, including repeated pops of the same source when it is the only non-empty one.
REQ-020 Latency: a pop in cycle N produces the source word via fifo_valid in cycle N+1, and push_out=1 with registered data_out and src_out in cycle N+2.
REQ-021 Words already in flight when PAUSED is entered (at most 2) are still pushed; no new pop is issued from the cycle after dest_pause is sampled high.
REQ-022 If fifo_valid of the granted source is 0 in cycle N+1, the word is dropped (no push) and err is set to 1 and stays 1 until reset.
REQ-023 A fifo_valid bit that is high for a source not popped in cycle N is ignored.
REQ-024 push_out is 0 in every cycle not covered by REQ-020; data_out and src_out hold their last value.

Reset
REQ-025 While reset_L=0: pop=0, push_out=0, data_out=0, src_out=0, err=0, state=IDLE, last_grant=3 (so source 0 is searched first).
REQ-026 Reset asserted mid-operation discards in-flight words; no push occurs in the cycle after release.

Configuration
REQ-027 Macro FIFO_ARB_STRICT_PRIO_EN: when defined, the grant is fixed priority (source 0 highest, source 3 lowest) and last_grant is unused; when undefined, round-robin per REQ-018.

Verification
REQ-028 Sources 0-3 each hold 2 words, dest_pause=0 -> pops follow 0,1,2,3,0,1,2,3; 8 pushes with src_out in the same order, first push 2 cycles after the first pop.
REQ-029 Only source 2 is non-empty with 3 words -> pop=4'b0100 for 3 consecutive cycles; 3 consecutive pushes with src_out=2; then IDLE.
REQ-030 dest_pause rises mid-stream -> at most 2 further pushes and pop=0; dest_continue=1 -> pops resume at the next round-robin source.
REQ-031 Pop source 1 with fifo_valid[1] held at 0 -> no push, err=1, and err stays 1 through later traffic until reset_L=0.
REQ-032 With FIFO_ARB_STRICT_PRIO_EN defined and all sources non-empty -> source 0 is popped until it is empty before any other source.
REQ-033 Assert reset_L=0 with 2 words in flight -> all outputs are 0 immediately; no push after release until a new pop.

Source files
------------

// File: rtl/fifo_rr_arbiter.sv
// Four-source FIFO arbiter with PAUSE/CONTINUE flow control toward one destination FIFO.
// Round-robin grant by default; define FIFO_ARB_STRICT_PRIO_EN for fixed priority (source 0 highest).
module fifo_rr_arbiter #(
    parameter int DATA_W = 6
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [3:0]            fifo_empty,
    input  logic [4*DATA_W-1:0]   fifo_data,
    input  logic [3:0]            fifo_valid,
    input  logic                  dest_pause,
    input  logic                  dest_continue,
    output logic [3:0]            pop,
    output logic                  push_out,
    output logic [DATA_W-1:0]     data_out,
    output logic [1:0]            src_out,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [3:0]        req;
    logic              any_req;
    logic [1:0]        grant_idx;
    logic              vld_p0;
    logic [1:0]        src_p0;
    logic              take_p0;
    logic              drop_p0;
    logic [DATA_W-1:0] word_p0;

    // Search order wraps, so the source after the last winner is tried first.
    function automatic logic [1:0] pick_rr(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = last + 2'd1;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [1:0] pick_fixed(input logic [3:0] r);
        logic [1:0] pick;
        pick = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (r[k]) pick = 2'(k);
        end
        return pick;
    endfunction

    function automatic logic [DATA_W-1:0] sel_word(input logic [4*DATA_W-1:0] d,
                                                   input logic [1:0] s);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            if (s == 2'(i)) w = d[i*DATA_W +: DATA_W];
        end
        return w;
    endfunction

    assign req     = ~fifo_empty;
    assign any_req = |req;

`ifdef FIFO_ARB_STRICT_PRIO_EN
    assign grant_idx = pick_fixed(req);
`else
    logic [1:0] last_grant;

    assign grant_idx = pick_rr(req, last_grant);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            last_grant <= 2'd3;
        end else if (|pop) begin
            last_grant <= grant_idx;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // PAUSE dominates CONTINUE whenever both are asserted.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (dest_pause)   state_nxt = PAUSED;
                else if (any_req) state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (dest_pause)    state_nxt = PAUSED;
                else if (!any_req) state_nxt = IDLE;
            end
            PAUSED: begin
                if (dest_continue && !dest_pause) state_nxt = ACTIVE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop = '0;
        if (state == ACTIVE && any_req) pop[grant_idx] = 1'b1;
    end

    // Stage p0: pop issued last cycle, source word expected on fifo_valid now
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= |pop;
        end
    end

    always_ff @(posedge clk) begin
        if (|pop) src_p0 <= grant_idx;
    end

    assign take_p0 = vld_p0 &  fifo_valid[src_p0];
    assign drop_p0 = vld_p0 & ~fifo_valid[src_p0];
    assign word_p0 = sel_word(fifo_data, src_p0);

    // Stage p1: registered push toward the destination FIFO
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            push_out <= 1'b0;
            data_out <= '0;
            src_out  <= 2'd0;
            err      <= 1'b0;
        end else begin
            push_out <= take_p0;
            if (take_p0) begin
                data_out <= word_p0;
                src_out  <= src_p0;
            end
            if (drop_p0) err <= 1'b1;
        end
    end

endmodule
